// File: rtl/ram_port_rr_arb2.sv
// Two-way round-robin grant for RAM port B, with an optional burst lock held by the last winner.
// The grant is combinational from valid; last_grant and locked update on the edge where a grant is taken.
module ram_port_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  logic last_grant;
  logic locked;

  // A lock can only be live here when both are valid and the holder is last_grant.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (locked) grant = last_grant ? 2'b10 : 2'b01;
        else        grant = last_grant ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      locked     <= 1'b0;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
      locked     <= grant[1] ? lock[1] : lock[0];
    end else begin
      locked     <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_portb_arbiter.sv
// Shares RAM port B between two requesters: registered command out, read data steered back by a 2-stage tag.
// Accepts one request per cycle; read response appears the cycle after the second edge following acceptance.
module ram_portb_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  input  logic                  REQ0_LOCK,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  input  logic                  REQ1_LOCK,
  output logic                  RSP0_VALID,
  output logic [DATA_WIDTH-1:0] RSP0_DATA,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP1_DATA,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  // Tag layout: {is_read, requester id}
  localparam int TAG_W = 2;

  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             accept;
  logic             sel;
  logic [TAG_W-1:0] tag1;
  logic [TAG_W-1:0] tag2;

  ram_port_rr_arb2 u_arb (
    .clk   (BUS_CLK),
    .rst   (BUS_RST),
    .valid ({REQ1_VALID, REQ0_VALID}),
    .lock  ({REQ1_LOCK, REQ0_LOCK}),
    .grant (grant)
  );

  assign ready      = grant & {2{~BUS_RST}};
  assign REQ0_READY = ready[0];
  assign REQ1_READY = ready[1];
  assign accept     = |ready;
  assign sel        = ready[1];

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      RAM_EN   <= 1'b0;
      RAM_WE   <= 1'b0;
      RAM_ADDR <= '0;
      RAM_DI   <= '0;
      tag1     <= '0;
      tag2     <= '0;
    end else begin
      tag2 <= tag1;
      if (accept) begin
        RAM_EN   <= 1'b1;
        RAM_WE   <= sel ? REQ1_WE : REQ0_WE;
        RAM_ADDR <= sel ? REQ1_ADDR : REQ0_ADDR;
        RAM_DI   <= sel ? REQ1_WDATA : REQ0_WDATA;
        tag1     <= {~(sel ? REQ1_WE : REQ0_WE), sel};
      end else begin
        RAM_EN   <= 1'b0;
        RAM_WE   <= 1'b0;
        tag1     <= '0;
      end
    end
  end

  assign RSP0_VALID = tag2[1] & ~tag2[0];
  assign RSP1_VALID = tag2[1] &  tag2[0];
  assign RSP0_DATA  = RAM_DO;
  assign RSP1_DATA  = RAM_DO;

endmodule
